// File: rtl/nn_pkg.sv
// Shared numeric types and helpers for the NN datapath stages.
// Accumulator and activation widths are fixed here so every layer stage agrees.
package nn_pkg;

    localparam int unsigned ACC_W  = 16;
    localparam int unsigned DATA_W = 8;

    typedef logic signed [ACC_W-1:0]  acc_t;
    typedef logic signed [DATA_W-1:0] data_t;

    localparam acc_t SAT_HI = acc_t'((2 ** (DATA_W - 1)) - 1);
    localparam acc_t SAT_LO = -SAT_HI - acc_t'(1);

    function automatic data_t sat_to_data(input acc_t v);
        if (v > SAT_HI) begin
            return data_t'(SAT_HI);
        end else if (v < SAT_LO) begin
            return data_t'(SAT_LO);
        end
        return data_t'(v);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head word; a push while full is dropped.
// The head register holds the last popped word once the FIFO drains.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             push_en, pop_en;

    assign full  = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = head_q;

    always_comb begin
        push_en  = push && !full;
        pop_en   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;

        if (push_en) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_en && !pop_en) begin
            count_d = count_q + (PTR_W + 1)'(1);
        end else if (pop_en && !push_en) begin
            count_d = count_q - (PTR_W + 1)'(1);
        end

        // Reading the next-state array covers the push-into-empty bypass.
        if (count_d != '0) begin
            head_d = mem_d[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/mac_output_stage.sv
// Extracts per-vector dot products from the MAC running sum, requantizes them
// to 8 bits and queues them behind a credit-controlled valid/ready interface.
module mac_output_stage
    import nn_pkg::*;
#(
    parameter int unsigned VEC_LEN    = 4,
    parameter int unsigned SHIFT      = 0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [ACC_W-1:0]  mac_f,
    input  logic                     mac_valid,
    input  logic                     relu_en,
    input  logic                     vec_start,
    output logic                     in_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     overflow_err
);

    localparam int unsigned CNT_W  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int unsigned CRED_W = $clog2(FIFO_DEPTH) + 1;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    acc_t              base_q, base_d;
    logic [CRED_W-1:0] credits_q, credits_d;
    logic              overflow_q, overflow_d;

    logic              complete;
    logic              fifo_full, fifo_empty;
    logic              pop, take;
    acc_t              dot, shifted;
    data_t             result;
    logic [DATA_W-1:0] fifo_head;

    always_comb begin
        complete = mac_valid && (cnt_q == CNT_W'(VEC_LEN - 1));
        cnt_d    = cnt_q;
        base_d   = base_q;
        if (complete) begin
            cnt_d  = '0;
            base_d = mac_f;
        end else if (mac_valid) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Modular difference stays exact across running-sum wraps.
    always_comb begin
        dot     = mac_f - base_q;
        shifted = dot >>> SHIFT;
        if (relu_en && (shifted < 0)) begin
            shifted = '0;
        end
        result = sat_to_data(shifted);
    end

    // A same-cycle pop frees the credit that vec_start claims, even at zero.
    always_comb begin
        pop       = !fifo_empty && out_ready;
        take      = vec_start && ((credits_q != '0) || pop);
        credits_d = credits_q;
        if (take && !pop) begin
            credits_d = credits_q - CRED_W'(1);
        end else if (pop && !take && (credits_q != CRED_W'(FIFO_DEPTH))) begin
            credits_d = credits_q + CRED_W'(1);
        end
        overflow_d = overflow_q || (complete && fifo_full);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            base_q     <= '0;
            credits_q  <= CRED_W'(FIFO_DEPTH);
            overflow_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            base_q     <= base_d;
            credits_q  <= credits_d;
            overflow_q <= overflow_d;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (complete),
        .push_data (result),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign out_data     = data_t'(fifo_head);
    assign out_valid    = !fifo_empty;
    assign in_ready     = (credits_q != '0);
    assign overflow_err = overflow_q;

endmodule

// File: tb/tb_mac_output_stage.sv
// Bench for mac_output_stage: four parameterizations share one stimulus stream
// and are checked every cycle against a product-level reference model.
module tb_mac_output_stage;

    localparam int NI = 4;
    localparam int VL [NI] = '{4, 4, 4, 1};
    localparam int SH [NI] = '{0, 8, 3, 0};
    localparam int DP [NI] = '{4, 4, 4, 2};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] mac_f = '0;
    logic        mac_valid = 1'b0;
    logic        relu_en = 1'b0;
    logic        vec_start = 1'b0;
    logic        out_ready = 1'b0;
    logic [NI-1:0] in_ready_v, out_valid_v, ovf_v;
    logic [7:0]  out_data_v [NI];

    int errors = 0;
    int checks = 0;
    int f = 0;
    int prod = 0;

    // Reference model state, kept per instance.
    int cred [NI];
    int pc   [NI];
    int vsum [NI];
    int mrd  [NI];
    int mwr  [NI];
    int last [NI];
    int mem  [NI][64];
    bit ovf  [NI];

    always #5 clk = ~clk;

    mac_output_stage #(.VEC_LEN(4), .SHIFT(0), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .reset(reset), .mac_f(mac_f), .mac_valid(mac_valid), .relu_en(relu_en),
        .vec_start(vec_start), .in_ready(in_ready_v[0]), .out_data(out_data_v[0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready), .overflow_err(ovf_v[0]));
    mac_output_stage #(.VEC_LEN(4), .SHIFT(8), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .reset(reset), .mac_f(mac_f), .mac_valid(mac_valid), .relu_en(relu_en),
        .vec_start(vec_start), .in_ready(in_ready_v[1]), .out_data(out_data_v[1]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready), .overflow_err(ovf_v[1]));
    mac_output_stage #(.VEC_LEN(4), .SHIFT(3), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .reset(reset), .mac_f(mac_f), .mac_valid(mac_valid), .relu_en(relu_en),
        .vec_start(vec_start), .in_ready(in_ready_v[2]), .out_data(out_data_v[2]),
        .out_valid(out_valid_v[2]), .out_ready(out_ready), .overflow_err(ovf_v[2]));
    mac_output_stage #(.VEC_LEN(1), .SHIFT(0), .FIFO_DEPTH(2)) u3 (
        .clk(clk), .reset(reset), .mac_f(mac_f), .mac_valid(mac_valid), .relu_en(relu_en),
        .vec_start(vec_start), .in_ready(in_ready_v[3]), .out_data(out_data_v[3]),
        .out_valid(out_valid_v[3]), .out_ready(out_ready), .overflow_err(ovf_v[3]));

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int sdata(input int k);
        return int'($signed(out_data_v[k]));
    endfunction

    function automatic int requant(input int dot, input int sh, input bit relu);
        int d = 1 << sh;
        int s = (dot >= 0) ? dot / d : -((-dot + d - 1) / d);
        if (relu && s < 0) s = 0;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return s;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            cred[k] = DP[k]; pc[k] = 0; vsum[k] = 0;
            mrd[k] = 0; mwr[k] = 0; last[k] = 0; ovf[k] = 1'b0;
        end
    endtask

    task automatic model_update();
        for (int k = 0; k < NI; k++) begin
            if (reset) begin
                cred[k] = DP[k]; pc[k] = 0; vsum[k] = 0;
                mrd[k] = 0; mwr[k] = 0; last[k] = 0; ovf[k] = 1'b0;
            end else begin
                int  occ = mwr[k] - mrd[k];
                bit  pop = (occ > 0) && out_ready;
                bit  take;
                if (pop) begin
                    last[k] = mem[k][mrd[k] % 64];
                    mrd[k]++;
                end
                take = vec_start && (cred[k] > 0 || pop);
                if (take && !pop) cred[k]--;
                else if (pop && !take && cred[k] < DP[k]) cred[k]++;
                if (mac_valid) begin
                    vsum[k] += prod;
                    pc[k]++;
                    if (pc[k] == VL[k]) begin
                        if (occ == DP[k]) begin
                            ovf[k] = 1'b1;
                        end else begin
                            mem[k][mwr[k] % 64] = requant(vsum[k], SH[k], relu_en);
                            mwr[k]++;
                        end
                        pc[k] = 0;
                        vsum[k] = 0;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < NI; k++) begin
            int occ = mwr[k] - mrd[k];
            check_eq($sformatf("u%0d_out_valid", k), int'(out_valid_v[k]), int'(occ > 0));
            check_eq($sformatf("u%0d_out_data", k), sdata(k),
                     (occ > 0) ? mem[k][mrd[k] % 64] : last[k]);
            check_eq($sformatf("u%0d_in_ready", k), int'(in_ready_v[k]), int'(cred[k] > 0));
            check_eq($sformatf("u%0d_overflow", k), int'(ovf_v[k]), int'(ovf[k]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    task automatic feed(input int a, input int b);
        prod = a * b;
        f = f + prod;
        mac_f = 16'(f);
        mac_valid = 1'b1;
        tick();
        mac_valid = 1'b0;
    endtask

    task automatic start_vec();
        vec_start = 1'b1;
        tick();
        vec_start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; mac_valid = 1'b0; vec_start = 1'b0;
        f = 0; mac_f = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic feed_vec4(input int first);
        feed(first, 1); feed(0, 0); feed(0, 0); feed(0, 0);
    endtask

    initial begin
        model_reset();
        do_reset();
        do_reset();
        check_eq("rst_out_valid", int'(out_valid_v[0]), 0);
        check_eq("rst_out_data", sdata(0), 0);
        check_eq("rst_in_ready", int'(in_ready_v[0]), 1);
        check_eq("rst_overflow", int'(ovf_v[0]), 0);

        // Basic dot product and relative second vector.
        out_ready = 1'b1;
        start_vec();
        feed(3, 4); feed(-2, 5); feed(7, 1); feed(1, 1);
        check_eq("basic_valid", int'(out_valid_v[0]), 1);
        check_eq("basic_dot", sdata(0), 10);
        start_vec();
        feed(100, 100); feed(100, 100); feed(100, 100); feed(-1, 1);
        check_eq("vec2_sat", sdata(0), 127);
        check_eq("vec2_shift8", sdata(1), 117);

        // ReLU and negative saturation.
        relu_en = 1'b1;
        feed(-10, 10); feed(-10, 10); feed(-10, 10); feed(0, 0);
        check_eq("relu_zero", sdata(0), 0);
        relu_en = 1'b0;
        feed(-10, 10); feed(-10, 10); feed(-10, 10); feed(0, 0);
        check_eq("neg_sat", sdata(0), -128);
        check_eq("neg_floor_shift8", sdata(1), -2);
        check_eq("neg_floor_shift3", sdata(2), -38);

        // Running-sum wrap: 32000 -> 33000 (wraps to -32536).
        do_reset();
        feed(125, 64); feed(125, 64); feed(125, 64); feed(125, 64);
        feed(250, 1); feed(250, 1); feed(250, 1); feed(250, 1);
        check_eq("wrap_mac_f", int'($signed(mac_f)), -32536);
        check_eq("wrap_shift3", sdata(2), 125);
        check_eq("wrap_no_ovf", int'(ovf_v[2]), 0);

        // Back-pressure and credits.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) start_vec();
        check_eq("cred_exhausted", int'(in_ready_v[0]), 0);
        start_vec();
        check_eq("cred_no_underflow", int'(in_ready_v[0]), 0);
        for (int i = 1; i <= 4; i++) feed_vec4(i);
        check_eq("full_head", sdata(0), 1);
        feed_vec4(50);
        check_eq("ovf_set", int'(ovf_v[0]), 1);
        check_eq("ovf_head_kept", sdata(0), 1);
        out_ready = 1'b1;
        vec_start = 1'b1;
        tick();
        vec_start = 1'b0;
        check_eq("pop_and_start", int'(in_ready_v[0]), 0);
        check_eq("drain_1", sdata(0), 2);
        tick();
        check_eq("drain_2", sdata(0), 3);
        tick();
        check_eq("drain_3", sdata(0), 4);
        tick();
        check_eq("drained_valid", int'(out_valid_v[0]), 0);
        check_eq("drained_hold", sdata(0), 4);
        check_eq("ovf_sticky", int'(ovf_v[0]), 1);

        // Reset mid-operation.
        do_reset();
        out_ready = 1'b0;
        feed_vec4(1); feed_vec4(2);
        feed(5, 5); feed(6, 6);
        do_reset();
        check_eq("midrst_valid", int'(out_valid_v[0]), 0);
        check_eq("midrst_in_ready", int'(in_ready_v[0]), 1);
        out_ready = 1'b1;
        start_vec();
        feed(3, 4); feed(-2, 5); feed(7, 1); feed(1, 1);
        check_eq("midrst_fresh", sdata(0), 10);

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            if (c % 50 == 0) relu_en = 1'($urandom_range(0, 1));
            vec_start = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 199) == 0) begin
                vec_start = 1'b0;
                do_reset();
            end else if ($urandom_range(0, 1) == 1) begin
                feed($urandom_range(0, 180) - 90, $urandom_range(0, 180) - 90);
            end else begin
                tick();
            end
        end
        vec_start = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mac_output_stage.md
Name: mac_output_stage

Overview:
- Downstream neighbour of the 8x8->16 signed multiply-accumulate unit, which keeps a running, never-cleared 16-bit sum `f` and pulses `valid_out` once per accumulated product.
- Counts accumulated products and, every VEC_LEN products, extracts the dot product as the modular difference from the previous snapshot.
- Requantizes the result (arithmetic shift, optional ReLU, saturate to signed 8 bits) and buffers it in a FIFO with valid/ready output.
- Grants per-vector credits so the upstream feeder never overruns the FIFO.

Parameters:
- VEC_LEN, 4: products per dot product; must be >= 1.
- SHIFT, 0: arithmetic right shift applied before saturation, range 0..15.
- FIFO_DEPTH, 4: result FIFO entries; power of 2, >= 2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- mac_f  in  16  signed running sum from the MAC `f` output.
- mac_valid  in  1  MAC `valid_out`; when high, mac_f already includes the newest product.
- relu_en  in  1  quasi-static; when 1, negative results become 0.
- vec_start  in  1  upstream pulse; claims one credit before the first valid_in of a vector.
- in_ready  out  1  credits available; upstream may pulse vec_start only while this is high.
- out_data  out  8  signed requantized result at the FIFO head.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accept; a pop occurs when out_valid && out_ready.
- overflow_err  out  1  sticky; a result arrived while the FIFO was full.

Behaviour:
- Reset values:
  - cnt = 0, base = 0, FIFO empty, credits = FIFO_DEPTH.
  - out_valid = 0, out_data = 0, in_ready = 1, overflow_err = 0.
  - Reset mid-vector discards the partial count and all FIFO contents.
  - The MAC must be reset in the same cycle so that base = 0 matches f = 0.
- Product counter: cnt increments on each mac_valid. When mac_valid && cnt == VEC_LEN-1, a vector completes:
  - dot = mac_f - base, computed mod 2^16.
  - base <= mac_f.
  - cnt <= 0.
  - The requantized result is pushed into the FIFO.
  - mac_valid is ignored when low; gaps between products are allowed.
- Wrap: the running sum may wrap freely. The difference is correct provided each true dot product lies in [-32768, 32767].
- Requantization, in order:
  - s = dot >>> SHIFT (arithmetic, floor).
  - If relu_en and s < 0, s = 0.
  - out = saturate(s) to [-128, 127].
- Latency: the result is visible at out_data with out_valid = 1 in the cycle after the completing mac_valid (registered push). No combinational path from mac_f to out_data.
- FIFO:
  - out_data is registered at the head; it shows the head entry whenever out_valid = 1, and holds the last popped value otherwise.
  - Push and pop in the same cycle: occupancy unchanged, ordering preserved. Pop when empty is ignored.
  - Push when full: result dropped, overflow_err set (sticky until reset), FIFO contents unchanged.
- Credits:
  - vec_start decrements credits; a pop increments them. Both in the same cycle leaves credits unchanged.
  - in_ready = (credits != 0).
  - vec_start while credits == 0 is ignored and does not underflow.
  - Under a correct upstream, FIFO overflow is impossible.
- VEC_LEN == 1: every mac_valid completes a vector.
- Back-to-back vectors need no idle cycle; base update and count restart happen in the same cycle as the push.

Decomposition:
- Shared package nn_pkg:
  - ACC_W = 16, DATA_W = 8.
  - Typedefs acc_t (signed [15:0]) and data_t (signed [7:0]).
  - Function sat_to_data(acc_t) returning data_t.
  - Future layer stages reuse all of these.
- One sub-module: sync_fifo, parameterized by width and depth, providing push, pop, full, empty and a registered head.
- Counter, base register, requantization and credit logic stay in mac_output_stage.

Test Plan:
- Basic dot product: VEC_LEN=4, SHIFT=0, relu_en=0. Feed MAC products 3*4, -2*5, 7*1, 1*1 (f = 12, 2, 9, 10) -> out_data = 10 one cycle after the 4th mac_valid, out_valid = 1.
- Second vector, relative result: products 100*100 x3, then -1*1 -> dot 29999 saturates to 127. Same vector with SHIFT=8 -> 117. Base reference taken correctly from f = 10.
- ReLU and negative saturation: vector sum -300, relu_en=1 -> 0. relu_en=0 -> -128.
- Running-sum wrap: drive mac_f through 32000 -> -32536 (wrapped) with a true vector sum of 1000 and SHIFT=3 -> 125. No overflow_err.
- Back-pressure and credits: FIFO_DEPTH=4, out_ready=0:
  - 4 vec_start pulses -> in_ready = 0; a 5th pulse is ignored.
  - Complete 4 vectors -> FIFO full.
  - Raise out_ready together with a vec_start -> in_ready stays 0; results drain in order.
  - Force a 5th completion while full -> overflow_err = 1, contents unchanged.
- Reset mid-operation: reset with cnt = 2 and 2 entries queued -> next cycle out_valid = 0, in_ready = 1. A following 4-product vector yields the correct fresh result.
